// File: rtl/host_link_pkg.sv
// Shared definitions for the host command link: framing bytes, command codes
// and the decoder state encoding.
package host_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam int unsigned NUM_EVENTS = 11;

    localparam logic [7:0] CMD_BLACK_TO_PLAY        = 8'h00;
    localparam logic [7:0] CMD_WHITE_TO_PLAY        = 8'h01;
    localparam logic [7:0] CMD_BLACK_WINS           = 8'h02;
    localparam logic [7:0] CMD_WHITE_WINS           = 8'h03;
    localparam logic [7:0] CMD_DRAW_GAME            = 8'h04;
    localparam logic [7:0] CMD_NORMAL_WAIT          = 8'h05;
    localparam logic [7:0] CMD_PLAYER_MUST_JUMP     = 8'h06;
    localparam logic [7:0] CMD_MORE_JUMPS_AVAILABLE = 8'h07;
    localparam logic [7:0] CMD_UNRECOVERABLE_ERROR  = 8'h08;
    localparam logic [7:0] CMD_DRAW_OFFER           = 8'h09;
    localparam logic [7:0] CMD_DID_NOT_MOVE         = 8'h0A;
    localparam logic [7:0] CMD_PING                 = 8'h0B;

    // Legacy-compatible state encoding shared with the display integration.
    typedef logic [1:0] link_state_t;
    localparam link_state_t HUNT     = 2'd0;
    localparam link_state_t GOT_SYNC = 2'd1;
    localparam link_state_t GOT_CMD  = 2'd2;
    localparam link_state_t RESPOND  = 2'd3;

    // One-hot pulse vector for an event command; all zero for anything else.
    function automatic logic [NUM_EVENTS-1:0] cmd_onehot(input logic [7:0] cmd);
        logic [NUM_EVENTS-1:0] one;
        one = NUM_EVENTS'(1);
        if (cmd <= CMD_DID_NOT_MOVE) begin
            return one << cmd[3:0];
        end
        return '0;
    endfunction

endpackage

// File: rtl/host_command_decoder_if.sv
// Byte-level link between the UART receiver/transmitter and the command decoder.
interface host_command_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // master: the UART side, which supplies bytes and sinks responses
    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/link_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches Limit-1.
module link_timeout_counter #(
    parameter int unsigned Limit = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (Limit > 2) ? $clog2(Limit) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = enable && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/host_command_decoder.sv
// Frames SYNC/CMD/~CMD packets from the host, emits one-cycle status pulses,
// answers each packet with ACK/NAK and keeps a saturating link-error count.
module host_command_decoder
    import host_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    host_command_decoder_if.slave link,
    output logic [NUM_EVENTS-1:0] event_pulse,
    output logic [7:0]            err_count,
    output logic                  busy
);

    link_state_t           state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [NUM_EVENTS-1:0] event_q, event_d;
    logic [7:0]            err_q;
    logic                  err_inc;
    logic                  timeout_en;
    logic                  timeout_hit;

    assign timeout_en = (state_q == GOT_SYNC) || (state_q == GOT_CMD);

    link_timeout_counter #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (link.rx_valid),
        .enable  (timeout_en),
        .expired (timeout_hit)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_data_d = tx_data_q;
        event_d   = '0;
        err_inc   = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (link.rx_valid && (link.rx_data == SYNC_BYTE)) begin
                    state_d = GOT_SYNC;
                end
            end

            GOT_SYNC: begin
                // A received byte always takes priority over a same-cycle expiry.
                if (link.rx_valid) begin
                    cmd_d   = link.rx_data;
                    state_d = GOT_CMD;
                end else if (timeout_hit) begin
                    state_d = HUNT;
                    err_inc = 1'b1;
                end
            end

            GOT_CMD: begin
                if (link.rx_valid) begin
                    state_d = RESPOND;
                    if (link.rx_data != ~cmd_q) begin
                        tx_data_d = NAK_BYTE;
                        err_inc   = 1'b1;
                    end else if (cmd_q <= CMD_DID_NOT_MOVE) begin
                        event_d   = cmd_onehot(cmd_q);
                        tx_data_d = ACK_BYTE;
                    end else if (cmd_q == CMD_PING) begin
                        tx_data_d = ACK_BYTE;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        err_inc   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = HUNT;
                    err_inc = 1'b1;
                end
            end

            RESPOND: begin
                // No backpressure on the receiver, so bytes arriving now are lost.
                if (link.rx_valid) begin
                    err_inc = 1'b1;
                end
                if (link.tx_ready) begin
                    state_d   = HUNT;
                    tx_data_d = '0;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cmd_q     <= '0;
            tx_data_q <= '0;
            event_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tx_data_q <= tx_data_d;
            event_q   <= event_d;
            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign link.tx_data  = tx_data_q;
    assign link.tx_valid = (state_q == RESPOND);
    assign event_pulse   = event_q;
    assign err_count     = err_q;
    assign busy          = (state_q != HUNT);

endmodule
